// File: rtl/serial_frame_sequencer_pkg.sv
// rtl/serial_frame_sequencer_pkg.sv - shared state enum and constants for the serial frame sequencer
// PARITY_CHECK_EN adds the PAR state.
package serial_frame_sequencer_pkg;

  localparam int   PORT_BITS_DEFAULT = 2;
  localparam int   LEN_BITS_DEFAULT  = 4;
  localparam logic START_BIT         = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PORT = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
`ifdef PARITY_CHECK_EN
    ST_PAR  = 3'd4,
`endif
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/serial_frame_sequencer_seq_bit_counter.sv
// rtl/serial_frame_sequencer_seq_bit_counter.sv - loadable down-counter with terminal flag for header bit counts
module seq_bit_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement so the last bit of one field can arm the next field.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign term_o = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_sequencer.sv
// rtl/serial_frame_sequencer.sv - start/port/length/data frame sequencer stepped by a one-pulser enable
// Optional PARITY_CHECK_EN: even-parity bit after the data with a sticky parErr flag.
module serial_frame_sequencer
  import serial_frame_sequencer_pkg::*;
#(
  parameter int PORT_BITS = PORT_BITS_DEFAULT,
  parameter int LEN_BITS  = LEN_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkEn,
  input  logic                 serIn,
  output logic                 shEnPort,
  output logic                 shEnLen,
  output logic [PORT_BITS-1:0] portSel,
  output logic [LEN_BITS-1:0]  remLen,
  output logic                 serOutValid,
  output logic                 busy,
  output logic                 done,
  output logic                 parErr
);

  localparam int CNT_MAX = (PORT_BITS > LEN_BITS) ? PORT_BITS : LEN_BITS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef PARITY_CHECK_EN
  localparam state_e AFTER_DATA = ST_PAR;
`else
  localparam state_e AFTER_DATA = ST_DONE;
`endif

  state_e               state_q, state_d;
  logic [PORT_BITS-1:0] portSel_q, portSel_d;
  logic [LEN_BITS-1:0]  remLen_q, remLen_d;
  logic                 busy_q, done_q;
  logic [LEN_BITS-1:0]  len_shift;
  logic                 start;
  logic                 cnt_load, cnt_en, cnt_term;
  logic [CW-1:0]        cnt_val;
`ifdef PARITY_CHECK_EN
  logic                 par_q, par_d;
  logic                 parErr_q, parErr_d;
`endif

  assign start     = (state_q == ST_IDLE) && (serIn == START_BIT);
  assign len_shift = (remLen_q << 1) | LEN_BITS'(serIn);

  assign cnt_load = clkEn && (start || ((state_q == ST_PORT) && cnt_term));
  assign cnt_val  = start ? CW'(PORT_BITS - 1) : CW'(LEN_BITS - 1);
  assign cnt_en   = clkEn && ((state_q == ST_PORT) || (state_q == ST_LEN));

  seq_bit_counter #(.W(CW)) u_bit_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .en_i      (cnt_en),
    .term_o    (cnt_term)
  );

  always_comb begin
    state_d   = state_q;
    portSel_d = portSel_q;
    remLen_d  = remLen_q;
`ifdef PARITY_CHECK_EN
    par_d     = par_q;
    parErr_d  = parErr_q;
`endif
    if (clkEn) begin
      case (state_q)
        ST_IDLE: begin
          if (serIn == START_BIT) begin
            state_d   = ST_PORT;
            portSel_d = '0;
`ifdef PARITY_CHECK_EN
            par_d     = 1'b0;
            parErr_d  = 1'b0;
`endif
          end
        end
        ST_PORT: begin
          portSel_d = (portSel_q << 1) | PORT_BITS'(serIn);
          if (cnt_term) state_d = ST_LEN;
        end
        ST_LEN: begin
          remLen_d = len_shift;
          if (cnt_term) state_d = (len_shift == '0) ? AFTER_DATA : ST_DATA;
        end
        ST_DATA: begin
          if (remLen_q != '0) remLen_d = remLen_q - LEN_BITS'(1);
`ifdef PARITY_CHECK_EN
          par_d = par_q ^ serIn;
`endif
          if (remLen_q == LEN_BITS'(1)) state_d = AFTER_DATA;
        end
`ifdef PARITY_CHECK_EN
        ST_PAR: begin
          if (serIn != par_q) parErr_d = 1'b1;
          state_d = ST_DONE;
        end
`endif
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      portSel_q <= '0;
      remLen_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q     <= 1'b0;
      parErr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      portSel_q <= portSel_d;
      remLen_q  <= remLen_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
`ifdef PARITY_CHECK_EN
      par_q     <= par_d;
      parErr_q  <= parErr_d;
`endif
    end
  end

  // Strobes are gated by the step enable so they are single-cycle per pulse.
  assign shEnPort    = clkEn && (state_q == ST_PORT);
  assign shEnLen     = clkEn && (state_q == ST_LEN);
  assign serOutValid = clkEn && (state_q == ST_DATA);
  assign portSel     = portSel_q;
  assign remLen      = remLen_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef PARITY_CHECK_EN
  assign parErr      = parErr_q;
`else
  assign parErr      = 1'b0;
`endif

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    (clkEn && (state_q == ST_DATA)) |-> (remLen_q != '0));

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// tb/tb_serial_frame_sequencer.sv - self-checking bench for serial_frame_sequencer
module tb_serial_frame_sequencer;

  localparam int P = 2;
  localparam int L = 4;
`ifdef PARITY_CHECK_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         clk, rst, clkEn, serIn;
  logic         shEnPort, shEnLen, serOutValid, busy, done, parErr;
  logic [P-1:0] portSel;
  logic [L-1:0] remLen;
  int           checks = 0;
  int           failures = 0;

  serial_frame_sequencer #(.PORT_BITS(P), .LEN_BITS(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .clkEn      (clkEn),
    .serIn      (serIn),
    .shEnPort   (shEnPort),
    .shEnLen    (shEnLen),
    .portSel    (portSel),
    .remLen     (remLen),
    .serOutValid(serOutValid),
    .busy       (busy),
    .done       (done),
    .parErr     (parErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic en, input logic b);
    @(negedge clk);
    clkEn = en;
    serIn = b;
    #1;
  endtask

  // Frame model: the enabled-cycle index k fixes which field is on the wire.
  task automatic run_frame(input int port, input int len, input bit use_pat, input int pat,
                           input bit flip, input int gap, input int abort_k);
    logic       bits[$];
    logic       x, b, ep;
    logic [4:0] got, exp;
    int         t, fd;
    x = 1'b0;
    bits.push_back(1'b0);
    for (int i = P - 1; i >= 0; i--) bits.push_back(port[i]);
    for (int i = L - 1; i >= 0; i--) bits.push_back(len[i]);
    for (int i = len - 1; i >= 0; i--) begin
      b = use_pat ? pat[i] : 1'($urandom_range(0, 1));
      bits.push_back(b);
      x ^= b;
    end
    if (PB == 1) bits.push_back(x ^ flip);
    ep = (PB == 1) && flip;
    t  = bits.size();
    fd = 1 + P + L;
    for (int k = 0; k <= t; k++) begin
      step(1'b1, (k < t) ? bits[k] : 1'($urandom_range(0, 1)));
      got = {shEnPort, shEnLen, serOutValid, busy, done};
      exp = {(k >= 1 && k <= P), (k > P && k <= P + L), (k >= fd && k < fd + len), (k >= 1), (k == t)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL frame_cycle port=%0d len=%0d k=%0d got=%b exp=%b", port, len, k, got, exp);
      end
      if (k >= fd && k < fd + len) begin
        checks++;
        if (remLen !== L'(len - (k - fd))) begin
          failures++;
          $display("FAIL remlen_data len=%0d k=%0d got=%0d exp=%0d", len, k, remLen, len - (k - fd));
        end
      end
      if (k == 1) begin
        checks++;
        if (parErr !== 1'b0) begin
          failures++;
          $display("FAIL parerr_clear_on_start got=%b exp=0", parErr);
        end
      end
      if (k == t) begin
        checks++;
        if ({portSel, remLen, parErr} !== {P'(port), L'(0), ep}) begin
          failures++;
          $display("FAIL frame_done port/rem/par got=%0d/%0d/%b exp=%0d/0/%b", portSel, remLen, parErr, port, ep);
        end
      end
      if (k == abort_k) return;
      if (k < t) begin
        for (int g = 0; g < gap; g++) begin
          step(1'b0, 1'($urandom_range(0, 1)));
          got = {shEnPort, shEnLen, serOutValid, busy, done};
          exp = {3'b000, 1'b1, (k + 1 == t)};
          checks++;
          if (got !== exp) begin
            failures++;
            $display("FAIL gap_hold k=%0d g=%0d got=%b exp=%b", k, g, got, exp);
          end
        end
      end
    end
  endtask

  task automatic check_idle(input string name);
    step(1'b1, 1'b1);
    checks++;
    if ({busy, done, shEnPort, shEnLen, serOutValid} !== 5'b0) begin
      failures++;
      $display("FAIL %s busy/done/strobes got=%b exp=00000", name, {busy, done, shEnPort, shEnLen, serOutValid});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clkEn = 1'b0; serIn = 1'b1;
    repeat (2) @(negedge clk);
    clkEn = 1'b1;
    #1;
    checks++;
    if ({shEnPort, shEnLen, serOutValid, busy, done, parErr, portSel, remLen} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=0", {shEnPort, shEnLen, serOutValid, busy, done, parErr, portSel, remLen});
    end
    @(negedge clk);
    rst = 1'b1;
    check_idle("idle_after_reset");
  endtask

  task automatic test_basic();
    run_frame(2, 3, 1'b0, 0, 1'b0, 0, -1);
    check_idle("idle_after_basic");
  endtask

  task automatic test_zero_len();
    run_frame(3, 0, 1'b0, 0, 1'b0, 0, -1);
    check_idle("idle_after_zero_len");
  endtask

  task automatic test_slow_clken();
    run_frame(1, 5, 1'b0, 0, 1'b0, 4, -1);
    check_idle("idle_after_slow");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_frame($urandom_range(0, 3), $urandom_range(0, 15), 1'b0, 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), -1);
      check_idle("idle_after_random");
    end
  endtask

  task automatic test_back_to_back();
    run_frame(1, 2, 1'b0, 0, 1'b0, 0, -1);
    run_frame(2, 15, 1'b0, 0, 1'b0, 0, -1);
    run_frame(0, 1, 1'b0, 0, 1'b0, 1, -1);
  endtask

  task automatic test_reset_mid();
    run_frame(1, 7, 1'b0, 0, 1'b0, 0, 1 + P + L + 2);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({shEnPort, shEnLen, serOutValid, busy, done, parErr, portSel, remLen} !== '0) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=0", {shEnPort, shEnLen, serOutValid, busy, done, parErr, portSel, remLen});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) check_idle("idle_after_mid_reset");
    run_frame(2, 4, 1'b0, 0, 1'b0, 0, -1);
  endtask

  task automatic test_parity();
    run_frame(1, 3, 1'b1, 6, 1'b1, 0, -1);
    check_idle("idle_after_bad_parity");
    checks++;
    if (parErr !== ((PB == 1) ? 1'b1 : 1'b0)) begin
      failures++;
      $display("FAIL parerr_sticky got=%b exp=%b", parErr, (PB == 1));
    end
    run_frame(2, 3, 1'b1, 6, 1'b0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_slow_clken();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_sequencer.md
SERIAL_FRAME_SEQUENCER -- requirements
Module: serial_frame_sequencer

Interface
REQ-001 Parameter PORT_BITS, default 2, is the width of the port-select header field.
REQ-002 Parameter LEN_BITS, default 4, is the width of the data-length header field.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port clkEn, input, 1 bit: single-cycle step enable from the one-pulser; state advances only when it is high.
REQ-006 Port serIn, input, 1 bit: serial frame input.
REQ-007 Port shEnPort, output, 1 bit: shift strobe for the port-select field.
REQ-008 Port shEnLen, output, 1 bit: shift strobe for the length field.
REQ-009 Port portSel, output, PORT_BITS: registered destination port, MSB first.
REQ-010 Port remLen, output, LEN_BITS: data bits still to forward.
REQ-011 Port serOutValid, output, 1 bit: high when serIn is a valid data bit for portSel.
REQ-012 Port busy, output, 1 bit: high in every state except IDLE.
REQ-013 Port done, output, 1 bit: high while in DONE.
REQ-014 Port parErr, output, 1 bit: sticky parity-error flag (see Configuration).

Function
REQ-015 States: IDLE, PORT, LEN, DATA, PAR (macro only), DONE; all transitions require clkEn=1.
REQ-016 IDLE->PORT when serIn=0 (start bit); serIn=1 keeps IDLE.
REQ-017 PORT: PORT_BITS enabled cycles; each shifts serIn into portSel LSB, shEnPort=1; last bit -> LEN.
REQ-018 LEN: LEN_BITS enabled cycles; each shifts serIn into remLen, shEnLen=1; last bit -> DATA, or -> DONE (PAR with macro) when the assembled length is 0.
REQ-019 DATA: each enabled cycle serOutValid=1 and remLen decrements; when remLen=1 -> PAR (macro) else DONE.
REQ-020 DONE: stays until the next enabled cycle, then -> IDLE; serIn in DONE is ignored, no back-to-back start detection.
REQ-021 Strobes shEnPort, shEnLen and serOutValid are combinational: state AND clkEn; all are 0 whenever clkEn=0.
REQ-022 portSel and remLen hold their values in IDLE and DONE; portSel clears on IDLE->PORT.
REQ-023 remLen never wraps; a decrement at 0 is impossible by construction and is an assertion failure.
REQ-024 Latency: a frame with length N occupies 1+PORT_BITS+LEN_BITS+N(+1 parity) enabled cycles to DONE.

Reset
REQ-025 rst=0 forces IDLE asynchronously; portSel=0, remLen=0, parErr=0, all strobes, busy and done are 0.
REQ-026 Reset mid-frame discards the frame; after release, the next start bit begins a new frame.

Configuration
REQ-027 Macro PARITY_CHECK_EN: when defined, PAR follows DATA and samples one even-parity bit over the data bits; a mismatch sets parErr, which clears only on IDLE->PORT or reset.
REQ-028 Without PARITY_CHECK_EN: no PAR state exists, DATA/zero-length go straight to DONE, and parErr is tied 0.

Structure
REQ-029 The shared package holds the state enum, the default PORT_BITS/LEN_BITS constants, and the start-bit value constant.
REQ-030 One sub-module, seq_bit_counter: loadable down-counter with an enable and a terminal flag, used for the PORT/LEN bit counts.

Verification
REQ-031 clkEn=1; serIn=0,1,0,0,0,1,1,d,d,d -> shEnPort on cycles 2-3, shEnLen on 4-7, portSel=2, serOutValid on 8-10, done on 11.
REQ-032 Length 0 frame (0,1,1,0,0,0,0) -> portSel=3, no serOutValid, done on the cycle after the last length bit.
REQ-033 clkEn pulses every 5th clk during a frame -> state and strobes move only on clkEn cycles; strobes are 0 between pulses.
REQ-034 rst=0 asserted in DATA with remLen=5 -> immediate IDLE, all outputs 0; serIn=1 after release keeps IDLE.
REQ-035 With PARITY_CHECK_EN, data 1,1,0 and parity 1 -> parErr=1 after PAR; a next frame with a correct parity bit clears it on start.
